// File: rtl/sram_arb_rmw.sv
// sram_arb_rmw: two-requester round-robin controller for a single-port 4K x 32 SRAM.
// Sub-word writes are turned into read-modify-write so the macro only sees full words.
//
// Ports:
//   hclk, hresetn     clock, asynchronous active-low reset
//   req[1:0]          per-port request, held stable until the matching ack bit
//   we[1:0]           per-port direction (1 = write)
//   addr[2*AW-1:0]    per-port word address, port i at addr[i*AW +: AW]
//   wdata[63:0]       per-port write data, port i at wdata[i*32 +: 32]
//   be[7:0]           per-port byte enables, port i at be[i*4 +: 4]
//   ack[1:0]          one-cycle completion pulse to the served port
//   rdata[31:0]       read data, valid with a read ack, held otherwise
//   busy              high whenever the controller is not idle
//   sram_csn/wen/a/d  SRAM strobe (active low), write enable, address, write data
//   sram_q            SRAM read data, valid the cycle after a read strobe
module sram_arb_rmw #(
  parameter int unsigned AW = 12,
  parameter int unsigned DW = 32
) (
  input  logic            hclk,
  input  logic            hresetn,
  input  logic [1:0]      req,
  input  logic [1:0]      we,
  input  logic [2*AW-1:0] addr,
  input  logic [2*DW-1:0] wdata,
  input  logic [7:0]      be,
  output logic [1:0]      ack,
  output logic [DW-1:0]   rdata,
  output logic            busy,
  output logic            sram_csn,
  output logic            sram_wen,
  output logic [AW-1:0]   sram_a,
  output logic [DW-1:0]   sram_d,
  input  logic [DW-1:0]   sram_q
);

  typedef enum logic [2:0] {StIdle, StRd, StMerge, StCap, StWr, StAck} state_e;

  state_e          state_q, state_d;
  logic            last_gnt_q, last_gnt_d;
  logic            gnt_q, gnt_d;
  logic            op_we_q, op_we_d;
  logic [AW-1:0]   op_addr_q, op_addr_d;
  logic [DW-1:0]   op_wdata_q, op_wdata_d;
  logic [3:0]      op_be_q, op_be_d;
  logic [1:0]      ack_q, ack_d;
  logic [DW-1:0]   rdata_q, rdata_d;
  logic            busy_q, busy_d;
  logic            csn_q, csn_d;
  logic            wen_q, wen_d;
  logic [AW-1:0]   a_q, a_d;
  logic [DW-1:0]   d_q, d_d;

  // Arbitration: a lone requester wins; on contention the port not served last wins.
  logic            gnt_sel;
  logic            sel_we;
  logic [AW-1:0]   sel_addr;
  logic [DW-1:0]   sel_wdata;
  logic [3:0]      sel_be;
  logic [DW-1:0]   merged;

  assign gnt_sel   = (req == 2'b11) ? ~last_gnt_q : req[1];
  assign sel_we    = gnt_sel ? we[1]              : we[0];
  assign sel_addr  = gnt_sel ? addr[2*AW-1:AW]    : addr[AW-1:0];
  assign sel_wdata = gnt_sel ? wdata[2*DW-1:DW]   : wdata[DW-1:0];
  assign sel_be    = gnt_sel ? be[7:4]            : be[3:0];

  always_comb begin
    merged = sram_q;
    for (int k = 0; k < 4; k++) begin
      if (op_be_q[k]) merged[8*k +: 8] = op_wdata_q[8*k +: 8];
    end
  end

  always_comb begin
    state_d    = state_q;
    last_gnt_d = last_gnt_q;
    gnt_d      = gnt_q;
    op_we_d    = op_we_q;
    op_addr_d  = op_addr_q;
    op_wdata_d = op_wdata_q;
    op_be_d    = op_be_q;
    ack_d      = 2'b00;
    rdata_d    = rdata_q;
    csn_d      = 1'b1;
    wen_d      = wen_q;
    a_d        = a_q;
    d_d        = d_q;

    unique case (state_q)
      StIdle: begin
        if (|req) begin
          last_gnt_d = gnt_sel;
          gnt_d      = gnt_sel;
          op_we_d    = sel_we;
          op_addr_d  = sel_addr;
          op_wdata_d = sel_wdata;
          op_be_d    = sel_be;
          if (sel_we && sel_be == 4'hF) begin
            // Full-word write completes in a single strobe.
            state_d = StWr;
            csn_d   = 1'b0;
            wen_d   = 1'b1;
            a_d     = sel_addr;
            d_d     = sel_wdata;
            ack_d   = gnt_sel ? 2'b10 : 2'b01;
          end else if (sel_we && sel_be == 4'h0) begin
            // Null write: acknowledge without touching the SRAM.
            state_d = StAck;
            ack_d   = gnt_sel ? 2'b10 : 2'b01;
          end else begin
            // Read, or the read half of a read-modify-write.
            state_d = StRd;
            csn_d   = 1'b0;
            wen_d   = 1'b0;
            a_d     = sel_addr;
          end
        end
      end
      StRd:    state_d = op_we_q ? StMerge : StCap;
      StCap: begin
        rdata_d = sram_q;
        ack_d   = gnt_q ? 2'b10 : 2'b01;
        state_d = StAck;
      end
      StMerge: begin
        csn_d   = 1'b0;
        wen_d   = 1'b1;
        a_d     = op_addr_q;
        d_d     = merged;
        ack_d   = gnt_q ? 2'b10 : 2'b01;
        state_d = StWr;
      end
      StWr:    state_d = StIdle;
      StAck:   state_d = StIdle;
      default: state_d = StIdle;
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      state_q    <= StIdle;
      last_gnt_q <= 1'b1;
      gnt_q      <= 1'b0;
      op_we_q    <= 1'b0;
      op_addr_q  <= '0;
      op_wdata_q <= '0;
      op_be_q    <= 4'h0;
      ack_q      <= 2'b00;
      rdata_q    <= '0;
      busy_q     <= 1'b0;
      csn_q      <= 1'b1;
      wen_q      <= 1'b0;
      a_q        <= '0;
      d_q        <= '0;
    end else begin
      state_q    <= state_d;
      last_gnt_q <= last_gnt_d;
      gnt_q      <= gnt_d;
      op_we_q    <= op_we_d;
      op_addr_q  <= op_addr_d;
      op_wdata_q <= op_wdata_d;
      op_be_q    <= op_be_d;
      ack_q      <= ack_d;
      rdata_q    <= rdata_d;
      busy_q     <= busy_d;
      csn_q      <= csn_d;
      wen_q      <= wen_d;
      a_q        <= a_d;
      d_q        <= d_d;
    end
  end

  assign ack      = ack_q;
  assign rdata    = rdata_q;
  assign busy     = busy_q;
  assign sram_csn = csn_q;
  assign sram_wen = wen_q;
  assign sram_a   = a_q;
  assign sram_d   = d_q;

endmodule
